ysyx_25040105_lsu: RTL

//  Multi-cycle load/store unit for the NPC core. Replaces the direct combinational

---
 rtl/ysyx_25040105_lsu.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25040105_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_25040105_lsu
//
// Multi-cycle load/store unit for the NPC core. It sits between the EXU
// (address/store data) and the data-memory bus. It handshakes with the core
// through req_*/rsp_* and with the bus through mem_req_*/mem_rsp_*. It also
// handles byte-lane alignment, sign/zero extension, misalignment and illegal
// funct3 detection, and bus timeout detection.
//
// Parameters
//   ADDR_W   byte address width (>= 3); data width is fixed at 32
//   TIMEOUT  maximum number of cycles spent waiting for a bus response before
//            reporting a timeout; 0 disables the timeout
//
// Ports
//   clk, rst                  rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready       core request handshake
//   req_wen, req_funct3       store/load select and RV32 access type
//   req_addr, req_wdata       byte address and store data (rs2)
//   rsp_valid/rsp_ready       core response handshake (held until accepted)
//   rsp_rdata, rsp_err        extended load data, error code
//                             (00 ok, 01 misaligned, 10 timeout, 11 illegal)
//   mem_req_valid/ready       bus request handshake
//   mem_req_wen/addr          bus write enable, word-aligned address
//   mem_req_wdata/wmask       lane-replicated store data, byte write mask
//   mem_rsp_valid/rdata       single-cycle bus response and raw aligned word
// ---------------------------------------------------------------------------
module ysyx_25040105_lsu #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_wen,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_wmask,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    // The wait counter only has to reach TIMEOUT-1.
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state;
    state_t            state_next;

    logic              wen_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wmask_q;
    logic [CNT_W-1:0]  cnt;
    logic [31:0]       rdata_q;
    logic [1:0]        err_q;

    logic              illegal;
    logic              misaligned;
    logic [31:0]       lane_wdata;
    logic [3:0]        lane_wmask;
    logic [31:0]       load_shift;
    logic [31:0]       load_data;
    logic              timeout_hit;

    // Decode the incoming request. Illegal funct3 takes priority over
    // misalignment; misalignment is only meaningful for legal access sizes.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (req_wen) begin
            illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) |
                      (req_funct3 == 3'b111);
        end
        misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                     ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
    end

    // Store data is replicated across all lanes so the bus only has to look at
    // the write mask to pick the right bytes.
    always_comb begin
        lane_wdata = req_wdata;
        lane_wmask = 4'b1111;
        case (req_funct3[1:0])
            2'b00: begin
                lane_wdata = {4{req_wdata[7:0]}};
                lane_wmask = 4'b0001 << req_addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{req_wdata[15:0]}};
                lane_wmask = 4'b0011 << req_addr[1:0];
            end
            default: begin
            end
        endcase
    end

    // Move the addressed byte/half down to bit 0, then extend it according to
    // the latched access type.
    always_comb begin
        load_shift = mem_rsp_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{load_shift[7]}}, load_shift[7:0]};
            3'b001:  load_data = {{16{load_shift[15]}}, load_shift[15:0]};
            3'b100:  load_data = {24'd0, load_shift[7:0]};
            3'b101:  load_data = {16'd0, load_shift[15:0]};
            default: load_data = mem_rsp_rdata;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. A bus response arriving in the same
    // cycle as the timeout wins over the timeout.
    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        rsp_valid     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = (illegal || misaligned) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, wait counter and response registers. Store data and mask
    // are prepared at accept time so they stay stable for the whole ISSUE phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q    <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            wmask_q  <= 4'd0;
            cnt      <= '0;
            rdata_q  <= 32'd0;
            err_q    <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wen_q    <= req_wen;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr;
                        wdata_q  <= lane_wdata;
                        wmask_q  <= req_wen ? lane_wmask : 4'd0;
                        rdata_q  <= 32'd0;
                        if (illegal) begin
                            err_q <= ERR_ILLEGAL;
                        end else if (misaligned) begin
                            err_q <= ERR_MISALIGN;
                        end else begin
                            err_q <= ERR_OK;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_req_ready) begin
                        cnt <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mem_rsp_valid) begin
                        rdata_q <= wen_q ? 32'd0 : load_data;
                        err_q   <= ERR_OK;
                    end else if (timeout_hit) begin
                        rdata_q <= 32'd0;
                        err_q   <= ERR_TIMEOUT;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

endmodule
